uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
UART transmitter with a small input FIFO. It serialises bytes onto the tx line as 8N1, 8E1 or 8O1 frames, with 1 or 2 stop bits. Bit timing comes from the shared tick_16x strobe, which is the same oversampling enable that feeds the receive side. It sits between the bridge's SPI/command logic, which pushes bytes in, and the external TX pin.

Parameters:
FIFO_DEPTH, 4, number of byte entries; must be a power of 2, range 2..16.
PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst_n  in  1  synchronous, active-low reset.
tick_16x  in  1  one-clk enable strobe at 16x the baud rate.
wr_en  in  1  push request for din.
din  in  8  byte to transmit.
full  out  1  FIFO holds FIFO_DEPTH entries.
busy  out  1  a frame is in progress or the FIFO is non-empty.
tx  out  1  serial output; idles high.

Behaviour:
- Reset values (rst_n low at a clk edge): tx=1, full=0, busy=0, FIFO empty, read/write pointers=0, state=IDLE, sample_cnt=0, bit_idx=0. Reset mid-frame aborts the frame and drives tx=1 on the very next edge. FIFO contents are discarded.
- Push: when wr_en=1 and full=0 at an edge, din is stored at the tail. When wr_en=1 and full=1, the write is dropped silently and the FIFO is unchanged.
- full is evaluated before the edge. A push and a pop on the same edge while full: the push is dropped and the occupancy goes to FIFO_DEPTH-1.
- Push and pop on the same edge while not full and not empty: both happen and occupancy is unchanged.
- Occupancy counter width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the FIFO is non-empty at an edge, pop the head into the shift register, register tx=0, set sample_cnt=0, and go to START. tick_16x is not required for this.
  - Latency: a byte pushed at edge E into an empty, idle block gives tx=0 after edge E+1.
- Bit timing in START, DATA, PARITY and STOP:
  - On each tick_16x, sample_cnt increments.
  - On the tick where sample_cnt==15, the current bit ends, sample_cnt wraps to 0, and tx takes the next bit value on that same edge.
  - Every bit therefore lasts exactly 16 ticks.
- START to DATA with bit_idx=0; tx=shift[0]. Data is sent LSB first.
- DATA: bit_idx counts 0..7. After bit 7:
  - PARITY if PARITY!=0, with tx = XOR of data (even) or its inverse (odd);
  - otherwise STOP with tx=1.
- PARITY to STOP with tx=1.
- STOP: lasts 16*STOP_BITS ticks; a stop-bit counter selects which stop bit is active. At the end:
  - if the FIFO is non-empty, pop and go straight to START with tx=0 on the same edge (back-to-back frames, no idle gap);
  - otherwise go to IDLE.
- tick_16x is ignored in IDLE. wr_en is honoured in every state.
- busy = (state!=IDLE) OR (occupancy!=0), registered, updated on the same edge as the state and FIFO.
- full is registered and matches the post-edge occupancy.

Decomposition:
- Shared uart package, also used by the receive side:
  - state encodings UART_IDLE/START/DATA/PARITY/STOP;
  - PARITY_NONE/EVEN/ODD;
  - OVERSAMPLE=16;
  - DATA_BITS=8.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; ports wr_en, din, rd_en, dout, full, empty, count).
- Serializer FSM lives in uart_tx_fifo.

Test Plan:
1. Reset, then push 0x55 with tick_16x every 4 clk, PARITY=0, STOP_BITS=1.
   - tx=0 two edges after the push.
   - Then 1,0,1,0,1,0,1,0, then stop=1, each bit held 64 clk.
   - busy deasserts after the stop bit.
2. PARITY=1, push 0x07.
   - Parity bit = 1.
   - With PARITY=2 the parity bit = 0.
   - Frame length is 11 bits.
3. Push 4 bytes (0x11, 0x22, 0x33, 0x44) on consecutive edges, then push 0x99 while tx is still in the first frame.
   - full=1 once the FIFO holds 4 entries.
   - 0x99 is dropped.
   - tx emits the 4 frames back-to-back with no idle gap; busy stays 1 throughout.
4. STOP_BITS=2, push 0xA5.
   - Stop high for 32 ticks.
   - Next frame start no earlier than that.
5. Reset mid-data (after bit 3 of 0xFF, with 2 bytes queued).
   - tx=1, busy=0, full=0 one edge later.
   - No further frames after release.
6. With full=1, assert wr_en on the same edge as the STOP-to-START pop.
   - Write rejected.
   - Occupancy = 3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Holds the frame-state encodings, parity modes, oversampling ratio and a parity helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_PARITY,
        UART_STOP
    } uart_state_e;

    // Even parity makes the total count of ones even, so the bit is the XOR of the data.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count flags that reflect the post-edge occupancy.
// A push while full is dropped; a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_d;
    logic             push;
    logic             pop;

    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    always_comb begin
        count_d = count + CW'(push) - CW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Each bit lasts OVERSAMPLE ticks of tick_16x; queued bytes go out back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_16x,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       full,
    output logic       busy,
    output logic       tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST   = 1'(STOP_BITS - 1);

    logic                 fifo_rd;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        count_next;

    uart_state_e          state_q, state_d;
    logic [SW-1:0]        sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .din   (din),
        .rd_en (fifo_rd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = tick_16x && (sample_cnt_q == SAMPLE_LAST);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        fifo_rd      = 1'b0;

        if (state_q != UART_IDLE && tick_16x) sample_cnt_d = sample_cnt_q + 1'b1;

        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd      = 1'b1;
                    shift_d      = fifo_dout;
                    tx_d         = 1'b0;
                    sample_cnt_d = '0;
                    state_d      = UART_START;
                end
            end
            UART_START: begin
                if (bit_end) begin
                    state_d   = UART_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            UART_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == BIT_LAST) begin
                        if (PARITY != PARITY_NONE) begin
                            state_d = UART_PARITY;
                            tx_d    = parity_bit(shift_q, PARITY);
                        end else begin
                            state_d    = UART_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[bit_idx_d];
                    end
                end
            end
            UART_PARITY: begin
                if (bit_end) begin
                    state_d    = UART_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            UART_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q != STOP_LAST) begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end else if (!fifo_empty) begin
                        // Next frame starts on this edge: no idle gap between queued bytes.
                        fifo_rd = 1'b1;
                        shift_d = fifo_dout;
                        tx_d    = 1'b0;
                        state_d = UART_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = UART_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = UART_IDLE;
            end
        endcase

        // busy mirrors the post-edge state and occupancy; a push while full never lands.
        count_next = fifo_count + CW'(wr_en && !fifo_full) - CW'(fifo_rd);
        busy_d     = (state_d != UART_IDLE) || (count_next != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= UART_IDLE;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign full = fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover no/even/odd parity and two stop bits.
// tick_16x fires every 4 clk, so one bit is 64 clk; frames are sampled mid-bit by tick count.
module tb_uart_tx_fifo;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tick_16x = 1'b0;
    logic       wr_en    = 1'b0;
    logic [7:0] din      = 8'h00;
    logic [3:0] tx_all;
    logic [3:0] busy_all;
    logic [3:0] full_all;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tk       = 0;
    int start_tk = 0;
    int start_cyc = 0;
    int prev_start_cyc = 0;
    int bnd [12];
    logic [11:0] fbits [4];
    logic mon_busy = 1'b0;
    logic busy_gap = 1'b0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (tick_16x) tk++;
    end

    initial forever begin
        @(negedge clk);
        tick_16x = ((cyc + 1) % 4 == 0);
    end

    uart_tx_fifo #(.FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .wr_en(wr_en), .din(din),
        .full(full_all[0]), .busy(busy_all[0]), .tx(tx_all[0]));
    uart_tx_fifo #(.FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .wr_en(wr_en), .din(din),
        .full(full_all[1]), .busy(busy_all[1]), .tx(tx_all[1]));
    uart_tx_fifo #(.FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .wr_en(wr_en), .din(din),
        .full(full_all[2]), .busy(busy_all[2]), .tx(tx_all[2]));
    uart_tx_fifo #(.FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .wr_en(wr_en), .din(din),
        .full(full_all[3]), .busy(busy_all[3]), .tx(tx_all[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (mon_busy && !busy_all[0]) busy_gap = 1'b1;
    endtask

    task automatic advance_to(input int n);
        while (tk - start_tk < n) step();
    endtask

    task automatic wait_start(input int d);
        int i = 0;
        while (tx_all[d] !== 1'b0 && i < 3000) begin
            step();
            i++;
        end
        check("start_seen", 32'(i < 3000), 32'd1);
        prev_start_cyc = start_cyc;
        start_cyc      = cyc;
        start_tk       = tk;
    endtask

    // Samples n bits after the start bit of all instances, mid-bit, and records bit boundaries.
    task automatic sample_frame(input int d, input int n);
        for (int j = 0; j < 4; j++) fbits[j] = '0;
        advance_to(8);
        check("start_bit_low", 32'(tx_all[d]), 32'd0);
        for (int k = 0; k < n; k++) begin
            advance_to(16 * (k + 1));
            bnd[k] = cyc;
            advance_to(16 * (k + 1) + 8);
            for (int j = 0; j < 4; j++) fbits[j][k] = tx_all[j];
        end
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy_all !== 4'b0000 && i < 20000) begin
            step();
            i++;
        end
        check("all_idle", 32'(busy_all), 32'd0);
        repeat (10) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_bytes [4];
        logic       tx_low;
        logic       busy_seen;

        // Reset state
        rst_n = 1'b0;
        repeat (5) step();
        check("rst_tx", 32'(tx_all), 32'hF);
        check("rst_busy", 32'(busy_all), 32'h0);
        check("rst_full", 32'(full_all), 32'h0);
        rst_n = 1'b1;
        repeat (3) step();

        // 8N1 frame of 0x55 and push-to-start latency
        din = 8'h55; wr_en = 1'b1; step(); wr_en = 1'b0;
        check("t1_tx_idle_after_push", 32'(tx_all[0]), 32'd1);
        check("t1_busy_after_push", 32'(busy_all[0]), 32'd1);
        step();
        check("t1_tx_start", 32'(tx_all[0]), 32'd0);
        wait_start(0);
        sample_frame(0, 9);
        check("t1_frame", 32'(fbits[0][8:0]), 32'h155);
        check("t1_bit_clk", 32'(bnd[1] - bnd[0]), 32'd64);
        check("t1_data_clk", 32'(bnd[8] - bnd[0]), 32'd512);
        advance_to(159);
        check("t1_busy_in_stop", 32'(busy_all[0]), 32'd1);
        advance_to(160);
        check("t1_busy_done", 32'(busy_all[0]), 32'd0);
        check("t1_tx_idle", 32'(tx_all[0]), 32'd1);
        wait_idle();

        // Even and odd parity on 0x07; parity frames are 11 bits long
        din = 8'h07; wr_en = 1'b1; step(); wr_en = 1'b0;
        step();
        wait_start(1);
        sample_frame(1, 10);
        check("t2_even_frame", 32'(fbits[1][9:0]), 32'h307);
        check("t2_odd_frame", 32'(fbits[2][9:0]), 32'h207);
        advance_to(160);
        check("t2_nopar_done", 32'(busy_all[0]), 32'd0);
        advance_to(175);
        check("t2_par_busy_175", 32'(busy_all[1]), 32'd1);
        advance_to(176);
        check("t2_par_done_176", 32'(busy_all[1]), 32'd0);
        wait_idle();

        // Fill the FIFO behind a running frame, overflow, and push on the full pop edge
        din = 8'hC3; wr_en = 1'b1; step();
        din = 8'h11; step();
        wait_start(0);
        mon_busy = 1'b1;
        din = 8'h22; step();
        din = 8'h33; step();
        check("t3_not_full_3", 32'(full_all[0]), 32'd0);
        din = 8'h44; step();
        check("t3_full_4", 32'(full_all[0]), 32'd1);
        din = 8'h99; step();
        check("t3_full_after_drop", 32'(full_all[0]), 32'd1);
        wr_en = 1'b0;
        sample_frame(0, 9);
        check("t3_frame_c3", 32'(fbits[0][8:0]), 32'h1C3);
        advance_to(159);
        din = 8'h77; wr_en = 1'b1;
        advance_to(160);
        wr_en = 1'b0;
        check("t6_full_after_pop", 32'(full_all[0]), 32'd0);
        check("t6_tx_start", 32'(tx_all[0]), 32'd0);
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            wait_start(0);
            check("t3_no_gap", 32'(start_cyc - prev_start_cyc), 32'd640);
            sample_frame(0, 9);
            check("t3_frame", 32'(fbits[0][8:0]), {23'd0, 1'b1, exp_bytes[i]});
        end
        advance_to(159);
        mon_busy = 1'b0;
        check("t3_busy_held", 32'(busy_gap), 32'd0);
        advance_to(160);
        check("t3_busy_done", 32'(busy_all[0]), 32'd0);
        tx_low = 1'b0;
        repeat (800) begin
            step();
            if (tx_all[0] !== 1'b1) tx_low = 1'b1;
        end
        check("t3_no_extra_frame", 32'(tx_low), 32'd0);
        wait_idle();

        // Two stop bits: stop lasts 32 ticks before the queued frame starts
        din = 8'hA5; wr_en = 1'b1; step();
        din = 8'h5A; step();
        wr_en = 1'b0;
        wait_start(3);
        sample_frame(3, 10);
        check("t4_frame_2stop", 32'(fbits[3][9:0]), 32'h3A5);
        check("t4_frame_1stop", 32'(fbits[0][9:0]), 32'h1A5);
        advance_to(175);
        check("t4_stop2_high", 32'(tx_all[3]), 32'd1);
        advance_to(176);
        check("t4_next_start", 32'(tx_all[3]), 32'd0);
        wait_start(3);
        check("t4_frame_period", 32'(start_cyc - prev_start_cyc), 32'd704);
        sample_frame(3, 10);
        check("t4_frame2", 32'(fbits[3][9:0]), 32'h35A);
        wait_idle();

        // Reset in the middle of a data bit with two bytes queued
        din = 8'hFF; wr_en = 1'b1; step();
        din = 8'h12; step();
        wait_start(0);
        din = 8'h34; step();
        wr_en = 1'b0;
        advance_to(88);
        check("t5_busy_before_rst", 32'(busy_all[0]), 32'd1);
        rst_n = 1'b0;
        step();
        check("t5_rst_tx", 32'(tx_all), 32'hF);
        check("t5_rst_busy", 32'(busy_all), 32'h0);
        check("t5_rst_full", 32'(full_all), 32'h0);
        rst_n = 1'b1;
        tx_low    = 1'b0;
        busy_seen = 1'b0;
        repeat (1500) begin
            step();
            if (tx_all !== 4'hF) tx_low = 1'b1;
            if (busy_all !== 4'h0) busy_seen = 1'b1;
        end
        check("t5_no_frames", 32'(tx_low), 32'd0);
        check("t5_stays_idle", 32'(busy_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
